// File: rtl/param_mem_multiport.sv
// Multi-port latency-modelling memory responder: round-robin arbitration, fixed hit/miss latency.
// Define PARAM_MEM_PAGE_MODEL_EN to enable open-page tracking (hit latency); otherwise every access uses MISS_CYCLES.
module param_mem_multiport #(
   parameter int    NUM_PORTS   = 2,
   parameter int    ADDR_W      = 32,
   parameter int    DATA_W      = 256,
   parameter int    DEPTH       = 1024,
   parameter int    PAGE_W      = 12,
   parameter int    MISS_CYCLES = 10,
   parameter int    HIT_CYCLES  = 5,
   parameter string INIT_FILE   = "memory.lst"
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            read,
   input  logic [NUM_PORTS-1:0]            write,
   input  logic [NUM_PORTS*ADDR_W-1:0]     addr,
   input  logic [NUM_PORTS*DATA_W-1:0]     wdata,
   input  logic [NUM_PORTS*DATA_W/8-1:0]   wmask,
   output logic [NUM_PORTS-1:0]            resp,
   output logic [DATA_W-1:0]               rdata,
   output logic                            busy,
   output logic                            proto_err
);

   localparam int BYTES   = DATA_W / 8;
   localparam int OFF_W   = $clog2(BYTES);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int LAT_MAX = (MISS_CYCLES > HIT_CYCLES) ? MISS_CYCLES : HIT_CYCLES;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0]    mem [DEPTH];

   logic [NUM_PORTS-1:0] pending;
   logic                 grant_found;
   logic [PTR_W-1:0]     grant_sel;
   logic [PTR_W-1:0]     grant_q;
   logic [PTR_W-1:0]     rr_ptr;

   logic [ADDR_W-1:0]    addr_sel;
   logic [DATA_W-1:0]    wdata_sel;
   logic [BYTES-1:0]     wmask_sel;
   logic [CNT_W-1:0]     lat_sel;

   logic                 op_read_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [BYTES-1:0]     wmask_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 proto_err_q;
   logic                 err_set;
   logic                 grant_now;
   logic                 unused_addr;

   assign pending   = read | write;
   assign grant_now = (state == IDLE) && grant_found;

   // First pending port at or after the round-robin pointer, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!grant_found && pending[(int'(rr_ptr) + i) % NUM_PORTS]) begin
            grant_found = 1'b1;
            grant_sel   = PTR_W'((int'(rr_ptr) + i) % NUM_PORTS);
         end
      end
   end

   assign addr_sel    = addr[int'(grant_sel)*ADDR_W +: ADDR_W];
   assign wdata_sel   = wdata[int'(grant_sel)*DATA_W +: DATA_W];
   assign wmask_sel   = wmask[int'(grant_sel)*BYTES +: BYTES];
   assign unused_addr = ^addr_sel;

`ifdef PARAM_MEM_PAGE_MODEL_EN
   localparam int PG_W = ADDR_W - PAGE_W;

   logic            page_valid;
   logic [PG_W-1:0] open_page;
   logic [PG_W-1:0] page_q;

   assign lat_sel = (page_valid && (open_page == addr_sel[ADDR_W-1:PAGE_W]))
                    ? CNT_W'(HIT_CYCLES) : CNT_W'(MISS_CYCLES);

   // The open page only changes when an access completes, so a reset mid-access leaves no trace.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         page_valid <= 1'b0;
         open_page  <= '0;
         page_q     <= '0;
      end else begin
         if (grant_now)
            page_q <= addr_sel[ADDR_W-1:PAGE_W];
         if (state == RESP) begin
            page_valid <= 1'b1;
            open_page  <= page_q;
         end
      end
   end
`else
   assign lat_sel = CNT_W'(MISS_CYCLES);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Counter holds latency-1 at grant so the resp cycle lands exactly L cycles after grant.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_found) state_next = (lat_sel == CNT_W'(1)) ? RESP : WAIT;
         WAIT:    if (cnt_q == CNT_W'(1)) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign err_set = (grant_now && read[grant_sel] && write[grant_sel]) ||
                    ((state == WAIT) && !pending[grant_q]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr      <= '0;
         grant_q     <= '0;
         op_read_q   <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         cnt_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_q | err_set;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  grant_q   <= grant_sel;
                  op_read_q <= read[grant_sel];
                  idx_q     <= addr_sel[OFF_W +: IDX_W];
                  wdata_q   <= wdata_sel;
                  wmask_q   <= wmask_sel;
                  cnt_q     <= lat_sel - CNT_W'(1);
               end
            end
            WAIT: cnt_q <= cnt_q - CNT_W'(1);
            RESP: rr_ptr <= (grant_q == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_q + PTR_W'(1);
            default: ;
         endcase
      end
   end

   // Array contents survive reset; writes commit only in the resp cycle.
   always_ff @(posedge clk) begin
      if ((state == RESP) && !op_read_q) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wmask_q[b])
               mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end

   always_comb begin
      resp = '0;
      if (state == RESP)
         resp[grant_q] = 1'b1;
   end

   assign rdata     = ((state == RESP) && op_read_q) ? mem[idx_q] : '0;
   assign busy      = (state != IDLE);
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_param_mem_multiport.sv
// Directed bench for param_mem_multiport (2 ports, 256-bit lines); honours PARAM_MEM_PAGE_MODEL_EN.
module tb_param_mem_multiport;

   localparam int MISS = 10;
`ifdef PARAM_MEM_PAGE_MODEL_EN
   localparam int HIT = 5;
`else
   localparam int HIT = 10;
`endif

   logic         clk;
   logic         rst;
   logic [1:0]   read;
   logic [1:0]   write;
   logic [63:0]  addr;
   logic [511:0] wdata;
   logic [63:0]  wmask;
   logic [1:0]   resp;
   logic [255:0] rdata;
   logic         busy;
   logic         proto_err;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] LINE_A5 = {32{8'hA5}};
   localparam logic [255:0] LINE_FF = {32{8'hFF}};
   localparam logic [255:0] LINE_3C = {{31{8'hFF}}, 8'h3C};

   param_mem_multiport #(
      .NUM_PORTS(2), .ADDR_W(32), .DATA_W(256), .DEPTH(1024), .PAGE_W(12),
      .MISS_CYCLES(10), .HIT_CYCLES(5), .INIT_FILE("")
   ) dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wdata(wdata),
      .wmask(wmask), .resp(resp), .rdata(rdata), .busy(busy), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete access from an idle DUT; entered and left #1 after a rising edge.
   task automatic access(input int p, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] d, input logic [31:0] m, input int exp_lat,
                         input logic [255:0] exp_rd, input string tag);
      int n;
      logic got;
      logic [255:0] rd_cap;
      logic [1:0] resp_cap;
      n = 0;
      got = 1'b0;
      read[p] = rd;
      write[p] = wr;
      addr[p*32 +: 32] = a;
      wdata[p*256 +: 256] = d;
      wmask[p*32 +: 32] = m;
      while (!got && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (resp[p]) got = 1'b1;
      end
      rd_cap = rdata;
      resp_cap = resp;
      check({tag, " latency"}, n, exp_lat);
      check({tag, " rdata"}, rd_cap, exp_rd);
      check({tag, " resp onehot"}, resp_cap, 2'b01 << p);
      read[p] = 1'b0;
      write[p] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      int n;
      int total;
      int cnt0;
      int cnt1;
      int p;
      int seen;

      rst = 1'b0;
      read = '0;
      write = '0;
      addr = '0;
      wdata = '0;
      wmask = '0;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("reset resp", resp, 2'b00);
      check("reset rdata", rdata, 256'h0);
      check("reset busy", busy, 1'b0);
      check("reset proto_err", proto_err, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Full-line write then read back; first access is a page miss
      access(0, 1'b0, 1'b1, 32'h100, LINE_A5, 32'hFFFF_FFFF, MISS, 256'h0, "wr 0x100");
      access(0, 1'b1, 1'b0, 32'h100, 256'h0, 32'h0, HIT, LINE_A5, "rd 0x100");
      check("idle rdata zero", rdata, 256'h0);
      check("idle busy", busy, 1'b0);
      check("proto_err clean", proto_err, 1'b0);

      // Page behaviour from a fresh open-page state; 0x8100 aliases line of 0x100
      pulse_reset();
      access(0, 1'b1, 1'b0, 32'h0000, 256'h0, 32'h0, MISS, rdata, "rd 0x0000");
      access(0, 1'b1, 1'b0, 32'h2000, 256'h0, 32'h0, MISS, rdata, "rd 0x2000");
      access(0, 1'b1, 1'b0, 32'h2040, 256'h0, 32'h0, HIT, rdata, "rd 0x2040");
      access(1, 1'b1, 1'b0, 32'h8100, 256'h0, 32'h0, MISS, LINE_A5, "rd alias 0x8100");

      // Two ports held continuously: strict alternation starting at port 0
      pulse_reset();
      read = 2'b11;
      addr[31:0] = 32'h100;
      addr[63:32] = 32'h8100;
      total = 0;
      cnt0 = 0;
      cnt1 = 0;
      for (int cyc = 0; cyc < 300 && total < 8; cyc++) begin
         @(posedge clk); #1;
         if (resp != 2'b00) begin
            p = resp[1] ? 1 : 0;
            check($sformatf("rr order %0d", total), p, total % 2);
            check($sformatf("rr rdata %0d", total), rdata, LINE_A5);
            total++;
            if (p == 0) begin
               cnt0++;
               if (cnt0 == 4) read[0] = 1'b0;
            end else begin
               cnt1++;
               if (cnt1 == 4) read[1] = 1'b0;
            end
         end
      end
      check("rr total grants", total, 8);
      read = 2'b00;
      @(posedge clk); #1;

      // Byte-masked write and read&write protocol error
      access(0, 1'b0, 1'b1, 32'h300, LINE_FF, 32'hFFFF_FFFF, MISS, 256'h0, "wr ff line");
      access(0, 1'b0, 1'b1, 32'h300, 256'h3C, 32'h0000_0001, HIT, 256'h0, "wr byte0");
      access(0, 1'b1, 1'b0, 32'h300, 256'h0, 32'h0, HIT, LINE_3C, "rd masked line");
      check("proto_err before rw", proto_err, 1'b0);
      access(1, 1'b1, 1'b1, 32'h300, 256'h0, 32'hFFFF_FFFF, HIT, LINE_3C, "rw as read");
      check("proto_err after rw", proto_err, 1'b1);
      access(0, 1'b1, 1'b0, 32'h300, 256'h0, 32'h0, HIT, LINE_3C, "rd after rw");

      // Reset during WAIT drops the access silently
      read[0] = 1'b1;
      addr[31:0] = 32'h100;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("busy in wait", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("busy after reset", busy, 1'b0);
      check("proto_err after reset", proto_err, 1'b0);
      read[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (resp != 2'b00) seen++;
      end
      check("no resp after reset", seen, 0);

      // Granted read dropped early still completes and sets sticky error
      read[0] = 1'b1;
      addr[31:0] = 32'h100;
      n = 0;
      while (n < 60) begin
         @(posedge clk); #1;
         n++;
         if (n == 2) read[0] = 1'b0;
         if (resp[0]) break;
      end
      check("dropped latency", n, MISS);
      check("dropped rdata", rdata, LINE_A5);
      check("dropped proto_err", proto_err, 1'b1);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("proto_err sticky", proto_err, 1'b1);
      check("idle resp", resp, 2'b00);
      check("idle busy end", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
